// File: rtl/gain_splitter_pkg.sv
// Shared constants and types for the gain splitter / gain mixer family.
package gain_splitter_pkg;

  // Default sample/gain width and the matching Q1.(W-2) format constants.
  localparam int DEF_BITSIZE = 16;
  localparam int DEF_QFRAC   = DEF_BITSIZE - 2;
  localparam logic signed [DEF_BITSIZE-1:0] SAT_MAX = {1'b0, {(DEF_BITSIZE-1){1'b1}}};
  localparam logic signed [DEF_BITSIZE-1:0] SAT_MIN = {1'b1, {(DEF_BITSIZE-1){1'b0}}};

  // Channel count and the width of the slot counter that walks them.
  localparam int NCH    = 4;
  localparam int SLOT_W = $clog2(NCH);

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/gain_splitter_mul.sv
// Signed Q1.(W-2) multiply: full product, arithmetic shift (floor), clamp to W bits.
module sat_mul_q #(
  parameter int W  = 16,
  parameter int QF = W - 2
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  logic signed [2*W-1:0] p;
  logic signed [2*W-1:0] r;

  // Product, floor shift, then saturate into the W-bit signed range.
  always_comb begin
    p = a * b;
    r = p >>> QF;
    if (r > $signed({{(W+1){1'b0}}, {(W-1){1'b1}}})) begin
      y = {1'b0, {(W-1){1'b1}}};
    end else if (r < $signed({{(W+1){1'b1}}, {(W-1){1'b0}}})) begin
      y = {1'b1, {(W-1){1'b0}}};
    end else begin
      y = r[W-1:0];
    end
  end

endmodule

// File: rtl/gain_splitter.sv
// One mono sample in, four gain-scaled copies out, once per lrclk frame.
// A single multiplier is time-shared, one channel per bclk.
// valid is a one-cycle strobe with no back-pressure: out1..out4 change only
// on the cycle valid rises and must be taken by the consumer then or later
// (they hold until the next commit).
module gain_splitter
  import gain_splitter_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic                      lrclk,
  input  logic signed [BITSIZE-1:0] in,
  input  logic signed [BITSIZE-1:0] g1,
  input  logic signed [BITSIZE-1:0] g2,
  input  logic signed [BITSIZE-1:0] g3,
  input  logic signed [BITSIZE-1:0] g4,
  output logic signed [BITSIZE-1:0] out1,
  output logic signed [BITSIZE-1:0] out2,
  output logic signed [BITSIZE-1:0] out3,
  output logic signed [BITSIZE-1:0] out4,
  output logic                      valid,
  output logic                      overrun,
  output state_t                    state_dbg
);

  logic                      lrclk_prev;
  logic                      frame_edge;
  state_t                    state;
  state_t                    state_nx;
  logic [SLOT_W-1:0]         slot;
  logic signed [BITSIZE-1:0] in_h;
  logic signed [BITSIZE-1:0] g_h    [NCH];
  logic signed [BITSIZE-1:0] shadow [NCH];
  logic signed [BITSIZE-1:0] prod;
  logic                      capture;
  logic                      do_slot;
  logic                      do_commit;
  logic                      set_ovr;

  assign frame_edge = lrclk & ~lrclk_prev;
  assign state_dbg  = state;

  sat_mul_q #(.W(BITSIZE), .QF(BITSIZE - 2)) u_mul (
    .a (in_h),
    .b (g_h[slot]),
    .y (prod)
  );

  // lrclk history; starts high so a level held through reset is not an edge.
  always_ff @(posedge bclk) begin
    if (reset) lrclk_prev <= 1'b1;
    else       lrclk_prev <= lrclk;
  end

  // Sequencer state register.
  always_ff @(posedge bclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and datapath strobes; a frame edge always restarts capture.
  always_comb begin
    state_nx  = state;
    capture   = frame_edge;
    do_slot   = 1'b0;
    do_commit = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_edge) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (frame_edge) begin
          set_ovr  = 1'b1;
          state_nx = ST_RUN;
        end else begin
          do_slot = 1'b1;
          if (slot == SLOT_W'(NCH - 1)) state_nx = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_nx  = frame_edge ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Holding registers, per-slot shadow results, and the all-at-once commit.
  always_ff @(posedge bclk) begin
    if (reset) begin
      slot    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      in_h    <= '0;
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      out4    <= '0;
      for (int i = 0; i < NCH; i++) begin
        g_h[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      valid <= do_commit;
      if (set_ovr) overrun <= 1'b1;
      if (capture) begin
        in_h   <= in;
        g_h[0] <= g1;
        g_h[1] <= g2;
        g_h[2] <= g3;
        g_h[3] <= g4;
        slot   <= '0;
      end else if (do_slot) begin
        shadow[slot] <= prod;
        slot         <= slot + 1'b1;
      end
      if (do_commit) begin
        out1 <= shadow[0];
        out2 <= shadow[1];
        out3 <= shadow[2];
        out4 <= shadow[3];
      end
    end
  end

endmodule

// File: tb/tb_gain_splitter.sv
// Self-checking bench for gain_splitter (BITSIZE = 16).
module tb_gain_splitter;
  import gain_splitter_pkg::*;

  typedef logic [3:0][15:0] quad_t;
  typedef struct {
    logic [15:0] in;
    quad_t       g;
    quad_t       e;
  } vec_t;

  logic        bclk;
  logic        reset;
  logic        lrclk;
  logic [15:0] in_s;
  logic [15:0] g1, g2, g3, g4;
  logic [15:0] out1, out2, out3, out4;
  logic        valid;
  logic        overrun;
  state_t      st;

  int checks = 0;
  int errors = 0;

  gain_splitter #(.BITSIZE(16)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .lrclk     (lrclk),
    .in        (in_s),
    .g1        (g1),
    .g2        (g2),
    .g3        (g3),
    .g4        (g4),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .valid     (valid),
    .overrun   (overrun),
    .state_dbg (st)
  );

  // clock / reset
  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic quad_t get_outs();
    quad_t q;
    q[0] = out1; q[1] = out2; q[2] = out3; q[3] = out4;
    return q;
  endfunction

  task automatic check_quad(input string nm, input quad_t act, input quad_t exp);
    for (int c = 0; c < 4; c++) check($sformatf("%s_out%0d", nm, c + 1), 32'(act[c]), 32'(exp[c]));
  endtask

  // Reference: real-valued g*in with floor toward -inf, then clamp.
  function automatic logic [15:0] ref_scale(input logic [15:0] a, input logic [15:0] g);
    longint p, q;
    p = longint'($signed(a)) * longint'($signed(g));
    q = p / 16384;
    if (p < 0 && (p % 16384) != 0) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic quad_t ref_quad(input logic [15:0] a, input quad_t g);
    quad_t q;
    for (int c = 0; c < 4; c++) q[c] = ref_scale(a, g[c]);
    return q;
  endfunction

  function automatic vec_t mk(input logic [15:0] iv,
                              input logic [15:0] a1, a2, a3, a4,
                              input logic [15:0] e1, e2, e3, e4);
    vec_t v;
    v.in = iv;
    v.g[0] = a1; v.g[1] = a2; v.g[2] = a3; v.g[3] = a4;
    v.e[0] = e1; v.e[1] = e2; v.e[2] = e3; v.e[3] = e4;
    return v;
  endfunction

  // driver: present one frame (inputs scrambled right after edge 0) and check it
  task automatic drive_inputs(input logic [15:0] iv, input quad_t gv);
    in_s = iv; g1 = gv[0]; g2 = gv[1]; g3 = gv[2]; g4 = gv[3];
  endtask

  task automatic run_frame(input string nm, input logic [15:0] iv, input quad_t gv, input quad_t ev);
    int    lat;
    int    np;
    quad_t got;
    @(negedge bclk);
    lrclk = 1'b1;
    drive_inputs(iv, gv);
    lat = -1;
    np  = 0;
    got = get_outs();
    for (int k = 1; k <= 10; k++) begin
      @(negedge bclk);
      if (k == 1) drive_inputs(16'($urandom), {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      if (k == 2) lrclk = 1'b0;
      if (valid) begin
        np++;
        if (lat < 0) begin
          lat = k - 1;
          got = get_outs();
        end
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'd5);
    check({nm, "_pulses"}, 32'(np), 32'd1);
    check_quad(nm, got, ev);
    check_quad({nm, "_hold"}, get_outs(), ev);
  endtask

  vec_t  tbl [5];
  quad_t qa, qb, got1, got2;
  logic [15:0] ia, ib;

  initial begin
    int k1, k2, np;
    reset = 1'b1;
    lrclk = 1'b1;
    drive_inputs(16'h0, '0);

    // reset, with lrclk held high through release
    repeat (4) @(negedge bclk);
    reset = 1'b0;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge bclk);
      if (valid) np++;
    end
    check("hold_high_no_frame", 32'(np), 32'd0);
    check_quad("reset", get_outs(), '0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_state", 32'(st), 32'(ST_IDLE));
    lrclk = 1'b0;
    repeat (2) @(negedge bclk);

    // table-driven vectors: nominal, saturation, truncation
    tbl[0] = mk(16'h2000, 16'h4000, 16'h2000, 16'h0000, 16'hC000, 16'h2000, 16'h1000, 16'h0000, 16'hE000);
    tbl[1] = mk(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    tbl[2] = mk(16'h8000, 16'h0000, 16'h7FFF, 16'hC000, 16'h4000, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000);
    tbl[3] = mk(16'hFFFF, 16'h2000, 16'h0001, 16'hFFFF, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0002);
    tbl[4] = mk(16'h0001, 16'h2000, 16'h4000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h0001, 16'hFFFE);
    for (int i = 0; i < 5; i++) run_frame($sformatf("tbl%0d", i), tbl[i].in, tbl[i].g, tbl[i].e);

    // randomized frames against the reference model, biased toward extremes
    for (int i = 0; i < 12; i++) begin
      ia = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF) : 16'($urandom);
      for (int c = 0; c < 4; c++) qa[c] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      run_frame($sformatf("rnd%0d", i), ia, qa, ref_quad(ia, qa));
    end

    // frame edge coincident with COMMIT: both frames commit, no overrun
    ia = 16'h1234; qa = {16'h4000, 16'hC000, 16'h2000, 16'h7FFF};
    ib = 16'hF00D; qb = {16'h1111, 16'h8000, 16'h3FFF, 16'hE000};
    @(negedge bclk);
    lrclk = 1'b1; drive_inputs(ia, qa);
    k1 = -1; k2 = -1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge bclk);
      if (k == 1) lrclk = 1'b0;
      if (k == 5) begin lrclk = 1'b1; drive_inputs(ib, qb); end
      if (k == 6) lrclk = 1'b0;
      if (valid) begin
        if (k1 < 0) begin k1 = k; got1 = get_outs(); end
        else if (k2 < 0) begin k2 = k; got2 = get_outs(); end
      end
    end
    check("b2b_first_pulse", 32'(k1), 32'd6);
    check("b2b_second_pulse", 32'(k2), 32'd11);
    check_quad("b2b_a", got1, ref_quad(ia, qa));
    check_quad("b2b_b", got2, ref_quad(ib, qb));
    check("b2b_overrun", 32'(overrun), 32'd0);

    // second frame edge 3 bclk after the first: overrun, only frame 2 commits
    ia = 16'h4000; qa = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
    ib = 16'hC123; qb = {16'h2000, 16'h6000, 16'h9000, 16'h0100};
    @(negedge bclk);
    lrclk = 1'b1; drive_inputs(ia, qa);
    k1 = -1; np = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge bclk);
      if (k == 1) lrclk = 1'b0;
      if (k == 3) begin lrclk = 1'b1; drive_inputs(ib, qb); end
      if (k == 4) lrclk = 1'b0;
      if (valid) begin
        np++;
        if (k1 < 0) begin k1 = k; got1 = get_outs(); end
      end
    end
    check("ovr_pulses", 32'(np), 32'd1);
    check("ovr_pulse_time", 32'(k1), 32'd9);
    check_quad("ovr_frame2", got1, ref_quad(ib, qb));
    check("ovr_flag", 32'(overrun), 32'd1);
    qa = {16'h7000, 16'h1000, 16'hF000, 16'h4000};
    run_frame("after_ovr", 16'h2345, qa, ref_quad(16'h2345, qa));
    check("ovr_sticky", 32'(overrun), 32'd1);

    // reset during slot 2 with non-zero outputs; lrclk stays high through release
    check("pre_reset_nonzero", 32'(get_outs() != '0), 32'd1);
    @(negedge bclk);
    lrclk = 1'b1; drive_inputs(16'h3000, {16'h4000, 16'h4000, 16'h4000, 16'h4000});
    np = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge bclk);
      if (k == 3) reset = 1'b1;
      if (k == 4) begin
        check_quad("midrst", get_outs(), '0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_state", 32'(st), 32'(ST_IDLE));
        reset = 1'b0;
      end
      if (k > 4 && valid) np++;
    end
    check("midrst_no_frame", 32'(np), 32'd0);
    check("midrst_idle", 32'(st), 32'(ST_IDLE));
    lrclk = 1'b0;
    repeat (2) @(negedge bclk);
    qa = {16'h2000, 16'hA000, 16'h5555, 16'hFFFF};
    run_frame("post_reset", 16'h6ABC, qa, ref_quad(16'h6ABC, qa));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
